// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program loader: FSM state encoding and byte-order constants.
// Header is a 16-bit big-endian word count; each instruction word is 4 bytes, MSB first.
package mips_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_HI = 3'd1,
      HDR_LO = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
      RUN    = 3'd5,
      ERR    = 3'd6
   } state_t;

   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_W          = 16;

endpackage

// File: rtl/mips_prog_loader.sv
// Streams a length-prefixed big-endian program into instruction memory, holding the core in reset until done.
// One imem write per 4 accepted bytes (write lands the cycle after the 4th byte); in_ready drops during WRITE/RUN/ERR/IDLE.
module mips_prog_loader
   import mips_pkg::*;
#(
   parameter int IMEM_AW = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               cpu_rst,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [HDR_W:0] DEPTH = (HDR_W+1)'(1) << IMEM_AW;

   state_t             state;
   logic [BYTE_W-1:0]  hdr_hi;
   logic [HDR_W-1:0]   n_words;
   logic [IMEM_AW:0]   word_idx;
   logic [1:0]         byte_cnt;
   logic [23:0]        shift;
   logic               fire;
   logic [HDR_W-1:0]   hdr_n;
   logic [HDR_W-1:0]   next_idx;

   assign fire     = in_valid && in_ready;
   assign hdr_n    = {hdr_hi, in_data};
   assign next_idx = HDR_W'(word_idx) + HDR_W'(1);

   // Status outputs decode directly from the state flop, so they change only on clock edges.
   assign in_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
   assign busy     = in_ready || (state == WRITE);
   assign done     = (state == RUN);
   assign err      = (state == ERR);
   assign cpu_rst  = (state != RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         hdr_hi     <= '0;
         n_words    <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE: if (start) state <= HDR_HI;
            HDR_HI: if (fire) begin
               hdr_hi <= in_data;
               state  <= HDR_LO;
            end
            HDR_LO: if (fire) begin
               n_words  <= hdr_n;
               word_idx <= '0;
               byte_cnt <= '0;
               if (hdr_n == '0)
                  state <= RUN;
               else if ({1'b0, hdr_n} > DEPTH)
                  state <= ERR;
               else
                  state <= DATA;
            end
            DATA: if (fire) begin
               shift    <= {shift[15:0], in_data};
               byte_cnt <= byte_cnt + 2'd1;
               // Fourth byte completes the word; address/data latch here and stay put until the next write.
               if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_idx[IMEM_AW-1:0];
                  imem_wdata <= {shift, in_data};
                  state      <= WRITE;
               end
            end
            WRITE: begin
               word_idx <= word_idx + 1'b1;
               state    <= (next_idx == n_words) ? RUN : DATA;
            end
            RUN, ERR: if (start) state <= HDR_HI;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized scoreboard bench for mips_prog_loader: expected imem writes are queued by the stimulus
// and popped by an independent monitor on every write strobe.
module tb_mips_prog_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [4:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] prog[$];

   mips_prog_loader #(.IMEM_AW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rst === 1'b1 && imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=%h@%0d required=none", imem_wdata, imem_addr);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write_addr", 32'(imem_addr), 32'(e.addr));
            chk("write_data", imem_wdata, e.data);
         end
      end
   end

   // gap: -1 random, otherwise fixed number of idle cycles before presenting the byte.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) return;
         @(negedge clk);
      end
      total++;
      bad++;
      $display("FAIL byte_timeout actual=in_ready_low required=accept");
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
   endtask

   // Loads prog[] with header n; reference: word i goes to address i when 1<=n<=32.
   task automatic session(input int n, input int gap);
      pulse_start();
      if (n >= 1 && n <= 32)
         for (int i = 0; i < n; i++) exp_q.push_back('{addr: 5'(i), data: prog[i]});
      send_byte(8'(n >> 8), gap);
      send_byte(8'(n), gap);
      if (n >= 1 && n <= 32) begin
         for (int i = 0; i < n; i++)
            for (int k = 3; k >= 0; k--) send_byte(8'(prog[i] >> (8 * k)), gap);
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (n == 0) begin
         chk("n0_done", 32'(done), 32'd1);
         chk("n0_cpu_rst", 32'(cpu_rst), 32'd0);
      end else if (n > 32) begin
         chk("ovf_err", 32'(err), 32'd1);
         chk("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
         chk("ovf_in_ready", 32'(in_ready), 32'd0);
         repeat (3) @(negedge clk);
         chk("ovf_err_hold", 32'(err), 32'd1);
      end else begin
         for (int i = 0; i < 50 && !done; i++) @(negedge clk);
         chk("load_done", 32'(done), 32'd1);
         chk("load_cpu_rst", 32'(cpu_rst), 32'd0);
         chk("load_busy", 32'(busy), 32'd0);
      end
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic rand_prog(input int n);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_flags", {29'd0, busy, done, err}, 32'd0);

      // Reference two-word program, continuous then every-other-cycle valid.
      prog = '{32'h20080005, 32'h20090007};
      session(2, 0);
      session(2, 1);

      session(0, 0);
      session(33, 0);

      rand_prog(32);
      session(32, -1);
      for (int t = 0; t < 6; t++) begin
         int n;
         n = int'($urandom_range(1, 32));
         rand_prog(n);
         session(n, int'($urandom_range(0, 2)) - 1);
      end

      // Abort mid-word: reset after 2 of 4 data bytes, then reload from address 0.
      prog = '{32'hCAFEF00D};
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hCA, 0);
      send_byte(8'hFE, 0);
      @(negedge clk);
      in_data = 8'hF0;
      #2 rst = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("abort_imem_we", 32'(imem_we), 32'd0);
      chk("abort_addr", 32'(imem_addr), 32'd0);
      chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rand_prog(3);
      session(3, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter IMEM_AW, default 5, meaning instruction-memory word-address width (depth 2^IMEM_AW = 32 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins a load session.
REQ-005 SHALL have port in_valid, input, 1, source has a byte on in_data.
REQ-006 SHALL have port in_data, input, 8, program byte stream.
REQ-007 SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-008 SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-009 SHALL have port imem_addr, output, IMEM_AW, word address of the write.
REQ-010 SHALL have port imem_wdata, output, 32, instruction word to write.
REQ-011 SHALL have port cpu_rst, output, 1, active-high reset that holds the MIPS core.
REQ-012 SHALL have port busy, output, 1, load session in progress.
REQ-013 SHALL have port done, output, 1, program loaded and core released.
REQ-014 SHALL have port err, output, 1, header word count exceeded depth.

Function
REQ-015 SHALL implement states IDLE, HDR_HI, HDR_LO, DATA, WRITE, RUN, ERR.
REQ-016 SHALL transfer a byte only when in_valid and in_ready are both high on a rising edge.
REQ-017 SHALL drive in_ready high only in HDR_HI, HDR_LO and DATA.
REQ-018 SHALL move IDLE->HDR_HI on start, and from RUN or ERR back to HDR_HI on start; start is ignored in every other state.
REQ-019 SHALL take the first two accepted bytes as word count N, 16-bit big-endian (HDR_HI high byte, HDR_LO low byte).
REQ-020 SHALL, after the HDR_LO byte: go to RUN if N=0, to ERR if N>2^IMEM_AW, else to DATA.
REQ-021 SHALL assemble 4 accepted DATA bytes big-endian into one word (first byte = bits 31:24).
REQ-022 SHALL, the cycle after the 4th byte is accepted, be in WRITE with imem_we=1 for exactly one cycle, imem_addr = word index, imem_wdata = assembled word.
REQ-023 SHALL increment the word index after each WRITE and go to RUN when index reaches N, else back to DATA.
REQ-024 SHALL hold imem_we=0 and imem_addr/imem_wdata stable outside WRITE.
REQ-025 SHALL hold cpu_rst=1 in every state except RUN; cpu_rst=0 in RUN.
REQ-026 SHALL drive busy=1 in HDR_HI, HDR_LO, DATA and WRITE; done=1 only in RUN; err=1 only in ERR.
REQ-027 SHALL index word N-1 at address N-1; N=32 writes addresses 0..31 with no wrap-around.
REQ-028 SHALL ignore in_valid while in_ready is low; bytes presented then are not consumed.
REQ-029 SHALL, on start while in RUN, reassert cpu_rst on the next edge and restart the header phase.

Reset
REQ-030 SHALL, while rst=0, asynchronously force IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, word index=0, byte count=0.
REQ-031 SHALL abort any load in progress when rst falls; partial words are discarded; no further imem write occurs.

Structure
REQ-032 SHALL place the state encoding and byte-order constants in a shared package mips_pkg.
REQ-033 SHALL be a single module; no sub-module is required.

Verification
REQ-034 SHALL verify: rst low then high, no start -> cpu_rst=1, in_ready=0, imem_we=0 indefinitely.
REQ-035 SHALL verify: start, bytes 00 02 20 08 00 05 20 09 00 07 -> writes 0x20080005 @0 and 0x20090007 @1, one cycle each, then done=1 and cpu_rst=0.
REQ-036 SHALL verify: start, header 00 00 -> RUN next cycle, no imem write, done=1.
REQ-037 SHALL verify: start, header 00 21 (N=33) -> err=1, cpu_rst=1, in_ready=0, no writes.
REQ-038 SHALL verify: in_valid toggled every other cycle during DATA -> identical words and addresses as continuous stream, and byte offered during WRITE is not lost.
REQ-039 SHALL verify: rst pulled low after 2 of 4 data bytes -> immediate IDLE outputs; new session then loads from address 0 correctly.
